// File: rtl/fast_adder_4bit_pkg.sv
// Default sizing shared by the fast adder and its lookahead group.
// WIDTH must be a whole multiple of GROUP.
package fast_adder_4bit_pkg;
    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_GROUP = 4;
endpackage

// File: rtl/fast_adder_4bit_cla_group.sv
// One carry-lookahead group: all in-group carries come straight from g/p and cin,
// plus the group generate/propagate used by the next lookahead level.
module cla_group
    import fast_adder_4bit_pkg::*;
#(
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             group_g,
    output logic             group_p
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] c;
    logic             term_c;
    logic             term_g;

    assign g = a & b;
    assign p = a ^ b;

    // Kept apart from the carry block so group_g/group_p never appear to depend on cin.
    always_comb begin
        group_g = 1'b0;
        term_g  = 1'b0;
        for (int k = 0; k < GROUP; k++) begin
            term_g = g[k];
            for (int m = k + 1; m < GROUP; m++) begin
                term_g = term_g & p[m];
            end
            group_g = group_g | term_g;
        end
        group_p = &p;
    end

    // c[i] = (cin & p[0..i-1]) | OR over k<i of (g[k] & p[k+1..i-1]): a flat sum of products.
    always_comb begin
        c      = '0;
        term_c = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            term_c = cin;
            for (int m = 0; m < i; m++) begin
                term_c = term_c & p[m];
            end
            c[i] = term_c;
            for (int k = 0; k < i; k++) begin
                term_c = g[k];
                for (int m = k + 1; m < i; m++) begin
                    term_c = term_c & p[m];
                end
                c[i] = c[i] | term_c;
            end
        end
        sum = p ^ c;
    end

endmodule

// File: rtl/fast_adder_4bit.sv
// Unsigned carry-lookahead adder: combinational sum/cout from a and b, plus a
// one-cycle registered copy qualified by a valid flag.
module fast_adder_4bit
    import fast_adder_4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_valid
);

    localparam int NG = WIDTH / GROUP;
    // The adder has no carry-in; it stays in the equations so every group carry has the same form.
    localparam logic CIN = 1'b0;

    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG:0]   grp_c;
    logic          term;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .a       (a[gi*GROUP +: GROUP]),
            .b       (b[gi*GROUP +: GROUP]),
            .cin     (grp_c[gi]),
            .sum     (sum[gi*GROUP +: GROUP]),
            .group_g (grp_g[gi]),
            .group_p (grp_p[gi])
        );
    end

    // Second-level lookahead: each group carry-in straight from the group G/P terms.
    always_comb begin
        grp_c = '0;
        term  = 1'b0;
        for (int j = 0; j <= NG; j++) begin
            term = CIN;
            for (int m = 0; m < j; m++) begin
                term = term & grp_p[m];
            end
            grp_c[j] = term;
            for (int k = 0; k < j; k++) begin
                term = grp_g[k];
                for (int m = k + 1; m < j; m++) begin
                    term = term & grp_p[m];
                end
                grp_c[j] = grp_c[j] | term;
            end
        end
    end

    assign cout = grp_c[NG];

    // in_valid is a one-way strobe with no ready: each high cycle captures a result that
    // appears on sum_q/cout_q with out_valid high exactly one cycle later; sum_q holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q     <= '0;
            cout_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q  <= sum;
                cout_q <= cout;
            end
        end
    end

endmodule

// File: tb/tb_fast_adder_4bit.sv
// Bench for fast_adder_4bit: directed corner cases, exhaustive combinational sweep,
// registered-path checks and a randomized run against an arithmetic reference.
module tb_fast_adder_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       cout;
    logic [3:0] sum_q;
    logic       cout_q;
    logic       out_valid;

    int checks = 0;
    int passed = 0;

    logic [4:0] exp_q[$];
    logic [4:0] hold;
    logic       exp_valid;

    fast_adder_4bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .cout      (cout),
        .sum_q     (sum_q),
        .cout_q    (cout_q),
        .out_valid (out_valid)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model_add(input logic [3:0] x, input logic [3:0] y);
        int s;
        s = int'(x) + int'(y);
        return 5'(s);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic drive_ab(input logic [3:0] x, input logic [3:0] y);
        a = x;
        b = y;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'bx;
        in_valid = 1'bx;
        a        = '0;
        b        = '0;

        // combinational path with unknown controls and no clock dependency
        drive_ab(4'd5, 4'd7);
        check("comb_5_7_sum", 8'(sum), 8'd12);
        check("comb_5_7_cout", 8'(cout), 8'd0);
        drive_ab(4'd10, 4'd3);
        check("comb_10_3_sum", 8'(sum), 8'd13);
        check("comb_10_3_cout", 8'(cout), 8'd0);
        drive_ab(4'd15, 4'd1);
        check("wrap_15_1", 8'({cout, sum}), 8'h10);
        drive_ab(4'd15, 4'd15);
        check("wrap_15_15", 8'({cout, sum}), 8'h1e);
        drive_ab(4'd0, 4'd0);
        check("zero_0_0", 8'({cout, sum}), 8'h00);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                drive_ab(4'(i), 4'(j));
                check("sweep", 8'({cout, sum}), 8'((i + j) & 31));
            end
        end

        // registered path: reset for two edges
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check("rst_sum_q", 8'(sum_q), 8'd0);
        check("rst_cout_q", 8'(cout_q), 8'd0);
        check("rst_out_valid", 8'(out_valid), 8'd0);

        rst_n    = 1'b1;
        in_valid = 1'b1;
        a        = 4'd9;
        b        = 4'd8;
        tick();
        check("acc_9_8_sum_q", 8'(sum_q), 8'd1);
        check("acc_9_8_cout_q", 8'(cout_q), 8'd1);
        check("acc_9_8_valid", 8'(out_valid), 8'd1);

        in_valid = 1'b0;
        a        = 4'd2;
        b        = 4'd2;
        tick();
        check("idle_valid", 8'(out_valid), 8'd0);
        check("idle_hold_sum_q", 8'(sum_q), 8'd1);
        check("idle_hold_cout_q", 8'(cout_q), 8'd1);

        // reset wins over in_valid on the same edge
        rst_n    = 1'b0;
        in_valid = 1'b1;
        drive_ab(4'd3, 4'd4);
        check("rstmid_comb_pre", 8'(sum), 8'd7);
        tick();
        check("rstmid_valid", 8'(out_valid), 8'd0);
        check("rstmid_sum_q", 8'(sum_q), 8'd0);
        check("rstmid_cout_q", 8'(cout_q), 8'd0);
        check("rstmid_comb_post", 8'(sum), 8'd7);

        // randomized run: accepted results go through an expected queue
        hold = 5'd0;
        for (int n = 0; n < 300; n++) begin
            rst_n    = ($urandom_range(0, 15) != 0);
            in_valid = 1'($urandom_range(0, 1));
            drive_ab(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            check("rand_comb", 8'({cout, sum}), 8'(model_add(a, b)));
            if (!rst_n) begin
                exp_valid = 1'b0;
                exp_q.delete();
            end else if (in_valid) begin
                exp_valid = 1'b1;
                exp_q.push_back(model_add(a, b));
            end else begin
                exp_valid = 1'b0;
            end
            tick();
            if (!rst_n) hold = 5'd0;
            if (exp_valid && exp_q.size() > 0) hold = exp_q.pop_front();
            check("rand_valid", 8'(out_valid), 8'(exp_valid));
            check("rand_reg", 8'({cout_q, sum_q}), 8'(hold));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
